mult_32bit_seq: RTL and testbench
=================================

MULT_32BIT_SEQ -- requirements
Module: mult_32bit_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; only 32 is required to be supported.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request pulse, sampled only in IDLE or DONE.
REQ-005 SHALL have port is_signed, input, 1, selects two's-complement (1) or unsigned (0) multiply, sampled with start.
REQ-006 SHALL have port multiplicand, input, 32, operand A, sampled with start.
REQ-007 SHALL have port multiplier, input, 32, operand B, sampled with start.
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 SHALL have port done, output, 1, single-cycle pulse marking valid hi/lo.
REQ-010 SHALL have port hi, output, 32, upper 32 bits of the 64-bit product.
REQ-011 SHALL have port lo, output, 32, lower 32 bits of the 64-bit product.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 SHALL transition IDLE->RUN on a clock edge with start=1, latching operands, is_signed and clearing the accumulator and iteration counter.
REQ-014 SHALL in signed mode latch operand magnitudes and record result sign = sign(A) XOR sign(B); 0x80000000 magnitude SHALL be treated as 2^31 without overflow.
REQ-015 SHALL in each RUN cycle gate the multiplicand with the current multiplier LSB (bitwise AND of all 32 bits), add it into the upper accumulator half with carry, then shift the 65-bit {carry, accumulator} right by one.
REQ-016 SHALL use a 5-bit iteration counter; RUN SHALL last exactly 32 cycles, leaving RUN when the counter wraps from 31.
REQ-017 SHALL on RUN->DONE write hi/lo with the product, two's-complement negated over 64 bits when the recorded sign is 1.
REQ-018 SHALL assert done for exactly the one cycle spent in DONE; the first edge with done=1 is 33 edges after the accepting start edge.
REQ-019 SHALL hold busy=1 in RUN only, and 0 in IDLE and DONE.
REQ-020 SHALL ignore start while in RUN; operands and result are unaffected.
REQ-021 SHALL accept start in DONE (DONE->RUN, back-to-back); otherwise DONE->IDLE.
REQ-022 SHALL hold hi/lo stable from DONE until the next DONE; hi/lo SHALL NOT change during RUN.
REQ-023 SHALL ignore operand input changes after the accepting edge.

Reset
REQ-024 SHALL on rst_n=0 immediately force state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, accumulator=0, regardless of clock.
REQ-025 SHALL on reset during RUN abandon the operation with no done pulse; the first edge after deassertion with start=1 begins a fresh operation.

Structure
REQ-026 SHALL take the FSM state encoding (IDLE/RUN/DONE) and the iteration count constant (32) from the shared MiniMIPS package, for reuse by a later divider.
REQ-027 SHALL instantiate the existing and_32bit block as its only sub-module, for partial-product gating (multiplicand AND replicated multiplier LSB).

Verification
REQ-028 SHALL verify unsigned 3 x 5: done 33 edges after start, hi=0x00000000, lo=0x0000000F.
REQ-029 SHALL verify unsigned 0xFFFFFFFF x 0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001.
REQ-030 SHALL verify signed -2 x 3 and 0x80000000 x 0x80000000: hi=0xFFFFFFFF, lo=0xFFFFFFFA; and hi=0x40000000, lo=0x00000000.
REQ-031 SHALL verify start pulsed with new operands at RUN cycle 10: the result still equals the original product and only one done pulse occurs.
REQ-032 SHALL verify rst_n low at RUN cycle 16: busy/hi/lo go to 0 asynchronously, no done pulse, and the next 7 x 6 gives lo=0x0000002A.
REQ-033 SHALL verify back-to-back start in DONE: the second result is correct and the first result is held until the second done.

Source files
------------

// File: rtl/minimips_pkg.sv
// Shared MiniMIPS arithmetic definitions.
// Sequential FSM encoding and iteration count, reused by mul/div units.
package minimips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    localparam int ITER_COUNT = 32;

endpackage

// File: rtl/and_32bit.sv
// 32-bit bitwise AND.
// Ports: a, b operands; y = a & b.
module and_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    assign y = a & b;

endmodule

// File: rtl/mult_32bit_seq.sv
// Sequential shift-add 32x32 multiplier, signed or unsigned, 32 RUN cycles.
// Ports: clk, rst_n, start, is_signed, multiplicand, multiplier -> busy, done, hi, lo.
module mult_32bit_seq
    import minimips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    fsm_state_t         state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [4:0]         cnt;
    logic               neg;

    logic [WIDTH-1:0]   pp;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] prod;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // Partial product: multiplicand gated by the current multiplier LSB
    and_32bit u_and (
        .a (mcand),
        .b ({WIDTH{mplier[0]}}),
        .y (pp)
    );

    // Magnitudes: -0x80000000 wraps to 0x80000000, i.e. 2^31 unsigned
    assign a_neg = is_signed & multiplicand[WIDTH-1];
    assign b_neg = is_signed & multiplier[WIDTH-1];
    assign a_mag = a_neg ? -multiplicand : multiplicand;
    assign b_mag = b_neg ? -multiplier : multiplier;

    // Add into upper half with carry, then shift {carry, acc} right by one
    assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, pp};
    assign acc_nxt = {sum, acc[WIDTH-1:1]};
    assign prod    = neg ? -acc_nxt : acc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= a_neg ^ b_neg;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'(ITER_COUNT - 1)) begin
                        hi    <= prod[2*WIDTH-1:WIDTH];
                        lo    <= prod[WIDTH-1:0];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_32bit_seq.sv
// Self-checking bench for mult_32bit_seq.
// Directed vector table plus mid-run start, async reset and back-to-back cases.
module tb_mult_32bit_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mult_32bit_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .is_signed    (is_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
    );

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    localparam int NV = 11;
    vec_t v [NV];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic issue(input logic s, input logic [31:0] a,
                         input logic [31:0] b, input bit sync);
        if (sync) @(negedge clk);
        is_signed    = s;
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        is_signed    = ~s;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k + 1;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        int          pulses;
        int          holdbad;
        logic [63:0] cap;

        v[0]  = '{1'b0, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F};
        v[1]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        v[2]  = '{1'b1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        v[3]  = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        v[4]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        v[5]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        v[6]  = '{1'b1, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};
        v[7]  = '{1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        v[8]  = '{1'b0, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
        v[9]  = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
        v[10] = '{1'b0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};

        // Reset state
        #12;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < NV; i++) begin
            issue(v[i].sgn, v[i].a, v[i].b, 1'b1);
            chk($sformatf("v%0d_busy", i), {63'd0, busy}, 64'd1);
            wait_done(lat);
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'd33);
            chk($sformatf("v%0d_busy_done", i), {63'd0, busy}, 64'd0);
            chk($sformatf("v%0d_prod", i), {hi, lo}, {v[i].hi, v[i].lo});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pulse", i), {63'd0, done}, 64'd0);
            chk($sformatf("v%0d_hold", i), {hi, lo}, {v[i].hi, v[i].lo});
        end

        // Start pulse with new operands in the middle of RUN
        issue(1'b0, 32'd3, 32'd5, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        chk("mid_hilo_run", {hi, lo}, {v[NV-1].hi, v[NV-1].lo});
        is_signed    = 1'b0;
        multiplicand = 32'd7;
        multiplier   = 32'd6;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        pulses = 0;
        cap    = '0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                cap = {hi, lo};
            end
        end
        chk("mid_pulses", 64'(pulses), 64'd1);
        chk("mid_prod", cap, 64'h0000000F);

        // Asynchronous reset in the middle of RUN
        issue(1'b1, 32'hFFFFFFFE, 32'd3, 1'b1);
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("arst_nodone", 64'(pulses), 64'd0);
        issue(1'b0, 32'd7, 32'd6, 1'b1);
        wait_done(lat);
        chk("arst_next_lat", 64'(lat), 64'd33);
        chk("arst_next_prod", {hi, lo}, 64'h0000002A);

        // Back-to-back: start accepted in DONE
        issue(1'b0, 32'd3, 32'd5, 1'b1);
        wait_done(lat);
        chk("b2b_first", {hi, lo}, 64'h0000000F);
        issue(1'b1, 32'hFFFFFFFE, 32'd3, 1'b0);
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        chk("b2b_done_low", {63'd0, done}, 64'd0);
        lat     = -1;
        holdbad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k + 1;
                break;
            end
            if ({hi, lo} !== 64'h0000000F) holdbad++;
        end
        chk("b2b_hold", 64'(holdbad), 64'd0);
        chk("b2b_lat", 64'(lat), 64'd33);
        chk("b2b_second", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
